// File: rtl/instr_word_encoder_if.sv
// Descriptor-in / encoded-word-out bus for instr_word_encoder.
// The master side is the program sequencer; the slave side is the encoder.
interface instr_word_encoder_if #(
   parameter int CNT_W = 3
);
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_kind;
   logic [2:0]        in_funct3;
   logic              in_f7b5;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [31:0]       in_imm;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic              out_err;
   logic [CNT_W-1:0]  level;

   modport master (
      output in_valid, in_kind, in_funct3, in_f7b5, in_rd, in_rs1, in_rs2, in_imm,
      output out_ready,
      input  in_ready, out_valid, out_instr, out_err, level
   );

   modport slave (
      input  in_valid, in_kind, in_funct3, in_f7b5, in_rd, in_rs1, in_rs2, in_imm,
      input  out_ready,
      output in_ready, out_valid, out_instr, out_err, level
   );
endinterface

// File: rtl/instr_word_encoder.sv
// RV32I descriptor encoder (LOAD/STORE/RTYPE/ITYPE/BRANCH) feeding a small valid/ready FIFO.
// Optional macro ENC_RANGE_CHECK_EN turns out-of-range immediates into flagged NOPs.
module instr_word_encoder #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input logic                 clk,
   input logic                 rst_n,
   instr_word_encoder_if.slave bus
);
   localparam int          PTR_W     = $clog2(DEPTH);
   localparam logic [31:0] NOP       = 32'h0000_0013;
   localparam logic [6:0]  OP_LOAD   = 7'b0000011;
   localparam logic [6:0]  OP_STORE  = 7'b0100011;
   localparam logic [6:0]  OP_RTYPE  = 7'b0110011;
   localparam logic [6:0]  OP_ITYPE  = 7'b0010011;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;

   logic [31:0]      mem_instr [DEPTH];
   logic             mem_err   [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   logic             push;
   logic             pop;
   logic [31:0]      enc_word;
   logic             enc_err;
   logic [31:0]      imm;
   logic [2:0]       f3;
   logic             is_shift;
   logic             f7_eff;

   assign imm      = bus.in_imm;
   assign f3       = bus.in_funct3;
   assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
   assign f7_eff   = ((f3 == 3'b000) || (f3 == 3'b101)) ? bus.in_f7b5 : 1'b0;

`ifdef ENC_RANGE_CHECK_EN
   logic sext12_ok;
   logic sext13_ok;
   logic range_bad;

   assign sext12_ok = (&imm[31:11]) | ~(|imm[31:11]);
   assign sext13_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];

   always_comb begin
      range_bad = 1'b0;
      case (bus.in_kind)
         3'd0, 3'd1: range_bad = ~sext12_ok;
         3'd3:       range_bad = is_shift ? (|imm[31:5]) : ~sext12_ok;
         3'd4:       range_bad = ~sext13_ok;
         default:    range_bad = 1'b0;
      endcase
   end
`else
   logic unused_imm_hi;
   assign unused_imm_hi = ^imm[31:13];
`endif

   always_comb begin
      enc_word = NOP;
      enc_err  = 1'b0;
      case (bus.in_kind)
         3'd0: enc_word = {imm[11:0], bus.in_rs1, f3, bus.in_rd, OP_LOAD};
         3'd1: enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, f3, imm[4:0], OP_STORE};
         3'd2: enc_word = {1'b0, f7_eff, 5'b00000, bus.in_rs2, bus.in_rs1, f3, bus.in_rd,
                           OP_RTYPE};
         3'd3: begin
            if (is_shift)
               enc_word = {1'b0, bus.in_f7b5, 5'b00000, imm[4:0], bus.in_rs1, f3, bus.in_rd,
                           OP_ITYPE};
            else
               enc_word = {imm[11:0], bus.in_rs1, f3, bus.in_rd, OP_ITYPE};
         end
         3'd4: begin
            if ((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100))
               enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, f3, imm[4:1], imm[11],
                           OP_BRANCH};
            else
               enc_err = 1'b1;
         end
         default: enc_err = 1'b1;
      endcase
`ifdef ENC_RANGE_CHECK_EN
      if (range_bad)
         enc_err = 1'b1;
`endif
      // Flagged entries always carry a harmless NOP so the decoder never sees a partial word.
      if (enc_err)
         enc_word = NOP;
   end

   assign bus.in_ready  = (count != CNT_W'(DEPTH));
   assign bus.out_valid = (count != '0);
   assign bus.level     = count;
   assign bus.out_instr = bus.out_valid ? mem_instr[rd_ptr] : 32'h0;
   assign bus.out_err   = bus.out_valid ? mem_err[rd_ptr] : 1'b0;

   assign push = bus.in_valid & bus.in_ready;
   assign pop  = bus.out_valid & bus.out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem_instr[wr_ptr] <= enc_word;
            mem_err[wr_ptr]   <= enc_err;
            wr_ptr            <= wr_ptr + PTR_W'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_word_encoder.sv
// Self-checking bench for instr_word_encoder: encoding vector table plus FIFO corner sequences,
// all outputs checked through an expected-word scoreboard.
module tb_instr_word_encoder;
   localparam int DEPTH = 4;
   localparam int CNT_W = 3;
`ifdef ENC_RANGE_CHECK_EN
   localparam bit RANGE_CHK = 1'b1;
`else
   localparam bit RANGE_CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   instr_word_encoder_if #(.CNT_W(CNT_W)) bus ();

   instr_word_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      string       name;
      logic [2:0]  kind;
      logic [2:0]  f3;
      logic        f7b5;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] exp_instr;
      logic        exp_err;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic        err;
   } exp_t;

   exp_t sb[$];
   exp_t cur_exp;
   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic [2:0] kind, input logic [2:0] f3,
                               input logic f7b5, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm,
                               input logic [31:0] ei, input logic ee);
      vec_t v;
      v.name = name; v.kind = kind; v.f3 = f3; v.f7b5 = f7b5;
      v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
      v.exp_instr = ei; v.exp_err = ee;
      return v;
   endfunction

   // LOAD descriptors with distinct fields; expected word built arithmetically from the fields.
   function automatic vec_t load_vec(input int i);
      vec_t v;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [31:0] imm;
      rd  = 5'(i);
      rs1 = 5'(i + 1);
      imm = 32'(i * 4);
      v = mk($sformatf("load_%0d", i), 3'd0, 3'd2, 1'b0, rd, rs1, 5'd0, imm,
             (imm << 20) | (32'(rs1) << 15) | (32'd2 << 12) | (32'(rd) << 7) | 32'd3, 1'b0);
      return v;
   endfunction

   task automatic set_desc(input vec_t v);
      bus.in_kind   = v.kind;
      bus.in_funct3 = v.f3;
      bus.in_f7b5   = v.f7b5;
      bus.in_rd     = v.rd;
      bus.in_rs1    = v.rs1;
      bus.in_rs2    = v.rs2;
      bus.in_imm    = v.imm;
      cur_exp.name  = v.name;
      cur_exp.instr = v.exp_instr;
      cur_exp.err   = v.exp_err;
   endtask

   // Observe the handshakes that will complete at the next edge, then advance one cycle.
   task automatic tick();
      exp_t e;
      if (rst_n) begin
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_word", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check({e.name, "_instr"}, bus.out_instr, e.instr);
               check({e.name, "_err"}, 32'(bus.out_err), 32'(e.err));
            end
         end
         if (bus.in_valid && bus.in_ready)
            sb.push_back(cur_exp);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      int t;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      t = 0;
      while ((sb.size() != 0 || bus.out_valid) && t < 50) begin
         tick();
         t++;
      end
      check("drain_done", 32'(sb.size()), 32'd0);
      check("drain_level", 32'(bus.level), 32'd0);
   endtask

   initial begin
      vecs[0]  = mk("load_basic",  3'd0, 3'd2, 1'b0, 5'd5, 5'd2, 5'd0, 32'd8,         32'h0081_2283, 1'b0);
      vecs[1]  = mk("add",         3'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,         32'h0020_81B3, 1'b0);
      vecs[2]  = mk("sub",         3'd2, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,         32'h4020_81B3, 1'b0);
      vecs[3]  = mk("and_f7ign",   3'd2, 3'd7, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,         32'h0020_F1B3, 1'b0);
      vecs[4]  = mk("store",       3'd1, 3'd2, 1'b0, 5'd31, 5'd2, 5'd5, 32'd12,       32'h0051_2623, 1'b0);
      vecs[5]  = mk("beq_m4",      3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
      vecs[6]  = mk("kind6",       3'd6, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0,         32'h0000_0013, 1'b1);
      vecs[7]  = mk("br_f3_010",   3'd4, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0000_0013, 1'b1);
      vecs[8]  = mk("addi_800",    3'd3, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0000_0800,
                    RANGE_CHK ? 32'h0000_0013 : 32'h8000_0013, RANGE_CHK);
      vecs[9]  = mk("srai",        3'd3, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3,         32'h4030_D093, 1'b0);
      vecs[10] = mk("addi_m1",     3'd3, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
      vecs[11] = mk("kind5",       3'd5, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0,         32'h0000_0013, 1'b1);
      vecs[12] = mk("beq_odd",     3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFD,
                    RANGE_CHK ? 32'h0000_0013 : 32'hFE20_8EE3, RANGE_CHK);
      vecs[13] = mk("bne_p8",      3'd4, 3'd1, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0020_9463, 1'b0);
      vecs[14] = mk("load_m2048",  3'd0, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'hFFFF_F800, 32'h8000_8083, 1'b0);

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      set_desc(vecs[0]);

      // Reset state
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_instr", bus.out_instr, 32'd0);
      check("rst_out_err", 32'(bus.out_err), 32'd0);
      check("rst_level", 32'(bus.level), 32'd0);
      rst_n = 1'b1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Single push latency: visible right after the push edge
      set_desc(vecs[0]);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check("lat_out_valid", 32'(bus.out_valid), 32'd1);
      check("lat_out_instr", bus.out_instr, 32'h0081_2283);
      check("lat_level", 32'(bus.level), 32'd1);
      drain();

      // Encoding table, streamed with the consumer always ready
      bus.out_ready = 1'b1;
      foreach (vecs[i]) begin
         int t;
         set_desc(vecs[i]);
         bus.in_valid = 1'b1;
         t = 0;
         while (!bus.in_ready && t < 20) begin
            tick();
            t++;
         end
         check("table_accept", 32'(bus.in_ready), 32'd1);
         tick();
      end
      drain();

      // Fill to full with consumer stalled, then drain in order
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         set_desc(load_vec(10 + i));
         tick();
      end
      bus.in_valid = 1'b0;
      check("full_accepted", 32'(sb.size()), 32'd4);
      check("full_level", 32'(bus.level), 32'd4);
      check("full_in_ready", 32'(bus.in_ready), 32'd0);
      drain();

      // Simultaneous push/pop at level 2 across pointer wrap
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         set_desc(load_vec(20 + i));
         tick();
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_desc(load_vec(22 + i));
         tick();
         check($sformatf("steady_level_%0d", i), 32'(bus.level), 32'd2);
      end
      drain();

      // Reset mid-stream discards everything
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_desc(load_vec(30 + i));
         tick();
      end
      bus.in_valid = 1'b0;
      check("pre_rst_level", 32'(bus.level), 32'd3);
      rst_n = 1'b0;
      tick();
      sb.delete();
      rst_n = 1'b1;
      check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_level", 32'(bus.level), 32'd0);
      check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
      set_desc(load_vec(40));
      bus.in_valid = 1'b1;
      tick();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end
endmodule
